// File: rtl/hdmi_timing_gen_pkg.sv
// Shared timing constants for the HDMI output path: CEA-861 raster per RES define,
// GBA source geometry, derived window size/offsets, and the registered output bundle.
package hdmi_timing_gen_pkg;

`ifdef RES_720P
    localparam int FRAMEWIDTH  = 1280;
    localparam int FRAMEHEIGHT = 720;
    localparam int HFRONTPORCH = 110;
    localparam int HSYNCLEN    = 40;
    localparam int HBACKPORCH  = 220;
    localparam int VFRONTPORCH = 5;
    localparam int VSYNCLEN    = 5;
    localparam int VBACKPORCH  = 20;
    localparam int maxScaleCnt = 3;
`else
    localparam int FRAMEWIDTH  = 1920;
    localparam int FRAMEHEIGHT = 1080;
    localparam int HFRONTPORCH = 88;
    localparam int HSYNCLEN    = 44;
    localparam int HBACKPORCH  = 148;
    localparam int VFRONTPORCH = 4;
    localparam int VSYNCLEN    = 5;
    localparam int VBACKPORCH  = 36;
    localparam int maxScaleCnt = 5;
`endif

    localparam int widthMax  = FRAMEWIDTH + HFRONTPORCH + HSYNCLEN + HBACKPORCH;
    localparam int heightMax = FRAMEHEIGHT + VFRONTPORCH + VSYNCLEN + VBACKPORCH;

    localparam int GBA_WIDTH  = 240;
    localparam int GBA_HEIGHT = 160;

    localparam int GBA_WIN_W = GBA_WIDTH * (maxScaleCnt + 1);
    localparam int GBA_WIN_H = GBA_HEIGHT * (maxScaleCnt + 1);
    localparam int GBA_OFF_X = (FRAMEWIDTH - GBA_WIN_W) / 2;
    localparam int GBA_OFF_Y = (FRAMEHEIGHT - GBA_WIN_H) / 2;

    typedef struct packed {
        logic       h_sync;
        logic       v_sync;
        logic       de;
        logic       gba_win;
        logic [7:0] gba_x;
        logic [7:0] gba_y;
        logic       line_req;
        logic [7:0] line_req_y;
        logic       frame_start;
    } timing_out_t;

    // Centring offset of a window inside the active area.
    function automatic int win_offset(input int active, input int win);
        return (active - win) / 2;
    endfunction

endpackage

// File: rtl/hdmi_timing_gen_scale_counter.sv
// Two-level wrap counter: a sub-pixel counter 0..SCALE_MAX whose wrap steps a GBA coordinate.
// Outputs reflect the clear immediately, so the cleared position itself already reads 0.
module scaleCounter
    import hdmi_timing_gen_pkg::*;
#(
    parameter int SCALE_MAX = maxScaleCnt
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    output logic [2:0] sub,
    output logic [7:0] coord,
    output logic       carry
);

    localparam logic [2:0] SUB_LAST = 3'(SCALE_MAX);

    logic [2:0] sub_q, sub_d;
    logic [7:0] coord_q, coord_d;

    always_comb begin
        sub     = clr ? 3'd0 : sub_q;
        coord   = clr ? 8'd0 : coord_q;
        carry   = (sub == SUB_LAST);
        sub_d   = sub;
        coord_d = coord;
        if (en) begin
            if (carry) begin
                sub_d   = 3'd0;
                coord_d = coord + 8'd1;
            end else begin
                sub_d = sub + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sub_q   <= 3'd0;
            coord_q <= 8'd0;
        end else begin
            sub_q   <= sub_d;
            coord_q <= coord_d;
        end
    end

endmodule

// File: rtl/hdmi_timing_gen.sv
// Pixel-clock raster generator: CEA-861 sync/de, centred integer-scaled GBA window with
// source coordinates, and a one-line-ahead line request for the scaler's line buffer.
module hdmi_timing_gen
    import hdmi_timing_gen_pkg::*;
#(
    parameter int H_TOTAL   = widthMax,
    parameter int V_TOTAL   = heightMax,
    parameter int H_ACTIVE  = FRAMEWIDTH,
    parameter int V_ACTIVE  = FRAMEHEIGHT,
    parameter int SCALE_MAX = maxScaleCnt,
    parameter int H_FP      = HFRONTPORCH,
    parameter int H_SYNC    = HSYNCLEN,
    parameter int H_BP      = HBACKPORCH,
    parameter int V_FP      = VFRONTPORCH,
    parameter int V_SYNC    = VSYNCLEN,
    parameter int V_BP      = VBACKPORCH
) (
    input  logic       clk,
    input  logic       rst,
    output logic       hSync,
    output logic       vSync,
    output logic       de,
    output logic       gbaWin,
    output logic [7:0] gbaX,
    output logic [7:0] gbaY,
    output logic       lineReq,
    output logic [7:0] lineReqY,
    output logic       frameStart
);

    localparam int FACTOR = SCALE_MAX + 1;
    localparam int WIN_W  = GBA_WIDTH * FACTOR;
    localparam int WIN_H  = GBA_HEIGHT * FACTOR;
    localparam int OFF_X  = win_offset(H_ACTIVE, WIN_W);
    localparam int OFF_Y  = win_offset(V_ACTIVE, WIN_H);

    // The period never gets shorter than the porch/sync layout it has to contain.
    localparam int H_SUM = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_SUM = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST   = 12'(((H_SUM > H_TOTAL) ? H_SUM : H_TOTAL) - 1);
    localparam logic [11:0] V_LAST   = 12'(((V_SUM > V_TOTAL) ? V_SUM : V_TOTAL) - 1);
    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] WX_START = 12'(OFF_X);
    localparam logic [11:0] WX_END   = 12'(OFF_X + WIN_W);
    localparam logic [11:0] WY_START = 12'(OFF_Y);
    localparam logic [11:0] WY_END   = 12'(OFF_Y + WIN_H);
    localparam logic [7:0]  GBA_Y_LAST = 8'(GBA_HEIGHT - 1);

    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] v_cnt_q, v_cnt_d;
    logic [11:0] nv;
    logic        h_wrap, in_win_x, in_win_y, sy_clr, sy_en;
    logic [2:0]  sx_sub_unused, sy_sub_unused;
    logic        sx_carry_unused, sy_carry;
    logic [7:0]  gba_x_cnt, gba_y_cnt, req_y;
    logic        req_row0, req_next, line_req;
    timing_out_t out_d, out_q;

    always_comb begin
        h_wrap  = (h_cnt_q == H_LAST);
        h_cnt_d = h_wrap ? 12'd0 : h_cnt_q + 12'd1;
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? 12'd0 : v_cnt_q + 12'd1;
        end
        nv       = (v_cnt_q == V_LAST) ? 12'd0 : v_cnt_q + 12'd1;
        in_win_x = (h_cnt_q >= WX_START) && (h_cnt_q < WX_END);
        in_win_y = (v_cnt_q >= WY_START) && (v_cnt_q < WY_END);
        sy_clr   = (v_cnt_q == WY_START) && (h_cnt_q == 12'd0);
        sy_en    = h_wrap && in_win_y;
    end

    scaleCounter #(
        .SCALE_MAX(SCALE_MAX)
    ) u_sx (
        .clk  (clk),
        .rst  (rst),
        .clr  (h_cnt_q == WX_START),
        .en   (in_win_x),
        .sub  (sx_sub_unused),
        .coord(gba_x_cnt),
        .carry(sx_carry_unused)
    );

    scaleCounter #(
        .SCALE_MAX(SCALE_MAX)
    ) u_sy (
        .clk  (clk),
        .rst  (rst),
        .clr  (sy_clr),
        .en   (sy_en),
        .sub  (sy_sub_unused),
        .coord(gba_y_cnt),
        .carry(sy_carry)
    );

    // The next line starts a new GBA row either at the window top or when sy is about to wrap.
    always_comb begin
        req_row0 = (nv == WY_START);
        req_next = in_win_y && sy_carry && (gba_y_cnt != GBA_Y_LAST);
        line_req = (h_cnt_q == H_ACT) && (req_row0 || req_next);
        req_y    = req_row0 ? 8'd0 : gba_y_cnt + 8'd1;

        out_d             = '0;
        out_d.h_sync      = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
        out_d.v_sync      = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
        out_d.de          = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        out_d.gba_win     = in_win_x && in_win_y;
        out_d.gba_x       = (in_win_x && in_win_y) ? gba_x_cnt : 8'd0;
        out_d.gba_y       = (in_win_x && in_win_y) ? gba_y_cnt : 8'd0;
        out_d.line_req    = line_req;
        out_d.line_req_y  = line_req ? req_y : out_q.line_req_y;
        out_d.frame_start = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q <= 12'd0;
            v_cnt_q <= 12'd0;
            out_q   <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            out_q   <= out_d;
        end
    end

    assign hSync      = out_q.h_sync;
    assign vSync      = out_q.v_sync;
    assign de         = out_q.de;
    assign gbaWin     = out_q.gba_win;
    assign gbaX       = out_q.gba_x;
    assign gbaY       = out_q.gba_y;
    assign lineReq    = out_q.line_req;
    assign lineReqY   = out_q.line_req_y;
    assign frameStart = out_q.frame_start;

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Bench for hdmi_timing_gen using two reduced rasters: A (scale 1, full frame) and
// B (scale 3, first lines), plus a mid-frame reset.
module tb_hdmi_timing_gen;

    localparam int A_HA = 260, A_HFP = 4, A_HS = 6, A_HBP = 2, A_HT = 272;
    localparam int A_VA = 170, A_VFP = 2, A_VS = 3, A_VBP = 1, A_VT = 176, A_S = 1;
    localparam int B_HA = 730, B_HFP = 2, B_HS = 3, B_HBP = 1, B_HT = 736;
    localparam int B_VA = 490, B_VFP = 2, B_VS = 2, B_VBP = 2, B_VT = 496, B_S = 3;
    localparam int A_FRAME = A_HT * A_VT;

    logic clk, rst;
    logic       a_hs, a_vs, a_de, a_win, a_lr, a_fs;
    logic [7:0] a_gx, a_gy, a_lry;
    logic       b_hs, b_vs, b_de, b_win, b_lr, b_fs;
    logic [7:0] b_gx, b_gy, b_lry;
    logic [29:0] a_vec, b_vec;

    int n_checks = 0;
    int n_pass   = 0;
    int ah, av, bh, bv, n_cyc;
    logic [7:0] ma_lry, mb_lry;
    logic stats_en;
    int lr_cnt, first_lr_n, last_lr_n, fs2_n, hs_cnt, hs_first;
    logic [7:0] first_lr_y, last_lr_y;

    hdmi_timing_gen #(
        .H_TOTAL(A_HT), .V_TOTAL(A_VT), .H_ACTIVE(A_HA), .V_ACTIVE(A_VA), .SCALE_MAX(A_S - 1),
        .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HBP), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VBP)
    ) dut_a (
        .clk(clk), .rst(rst), .hSync(a_hs), .vSync(a_vs), .de(a_de), .gbaWin(a_win),
        .gbaX(a_gx), .gbaY(a_gy), .lineReq(a_lr), .lineReqY(a_lry), .frameStart(a_fs)
    );

    hdmi_timing_gen #(
        .H_TOTAL(B_HT), .V_TOTAL(B_VT), .H_ACTIVE(B_HA), .V_ACTIVE(B_VA), .SCALE_MAX(B_S - 1),
        .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP)
    ) dut_b (
        .clk(clk), .rst(rst), .hSync(b_hs), .vSync(b_vs), .de(b_de), .gbaWin(b_win),
        .gbaX(b_gx), .gbaY(b_gy), .lineReq(b_lr), .lineReqY(b_lry), .frameStart(b_fs)
    );

    assign a_vec = {a_hs, a_vs, a_de, a_win, a_gx, a_gy, a_lr, a_lry, a_fs};
    assign b_vec = {b_hs, b_vs, b_de, b_win, b_gx, b_gy, b_lr, b_lry, b_fs};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference raster straight from the layout formulas; coordinates by division.
    function automatic logic [29:0] model(input int h, input int v, input int ha, input int hfp,
                                          input int hs, input int va, input int vfp, input int vs,
                                          input int vt, input int s, input logic [7:0] lry_prev,
                                          output logic [7:0] lry_next);
        int ww, wh, ox, oy, nv;
        logic hsy, vsy, d, win, lr, fs;
        logic [7:0] gx, gy;
        ww  = 240 * s;
        wh  = 160 * s;
        ox  = (ha - ww) / 2;
        oy  = (va - wh) / 2;
        hsy = (h >= ha + hfp) && (h < ha + hfp + hs);
        vsy = (v >= va + vfp) && (v < va + vfp + vs);
        d   = (h < ha) && (v < va);
        win = (h >= ox) && (h < ox + ww) && (v >= oy) && (v < oy + wh);
        gx  = win ? 8'((h - ox) / s) : 8'd0;
        gy  = win ? 8'((v - oy) / s) : 8'd0;
        nv  = (v + 1) % vt;
        lr  = (h == ha) && (nv >= oy) && (nv < oy + wh) && (((nv - oy) % s) == 0);
        lry_next = lr ? 8'((nv - oy) / s) : lry_prev;
        fs  = (h == 0) && (v == 0);
        return {hsy, vsy, d, win, gx, gy, lr, lry_next, fs};
    endfunction

    task automatic restart_model();
        ah = 0; av = 0; bh = 0; bv = 0; n_cyc = 0;
        ma_lry = 8'd0; mb_lry = 8'd0;
    endtask

    task automatic sample_cycle();
        logic [29:0] ea, eb;
        logic [7:0] nl;
        @(negedge clk);
        n_cyc++;
        ea = model(ah, av, A_HA, A_HFP, A_HS, A_VA, A_VFP, A_VS, A_VT, A_S, ma_lry, nl);
        ma_lry = nl;
        chk($sformatf("A_raster h=%0d v=%0d", ah, av), 32'(a_vec), 32'(ea));
        eb = model(bh, bv, B_HA, B_HFP, B_HS, B_VA, B_VFP, B_VS, B_VT, B_S, mb_lry, nl);
        mb_lry = nl;
        chk($sformatf("B_raster h=%0d v=%0d", bh, bv), 32'(b_vec), 32'(eb));

        if (ah == 0 && av == 0)     chk("A_frame_start", 32'({a_fs, a_de}), 32'(2'b11));
        if (ah == 9 && av == 5)     chk("A_win_before", 32'(a_win), 32'(0));
        if (ah == 10 && av == 5)    chk("A_win_first", 32'({a_win, a_gx, a_gy}), 32'({1'b1, 8'd0, 8'd0}));
        if (ah == 249 && av == 164) chk("A_win_last", 32'({a_win, a_gx, a_gy}), 32'({1'b1, 8'd239, 8'd159}));
        if (ah == 250 && av == 164) chk("A_win_after", 32'({a_win, a_gx}), 32'(0));
        if (ah == 260 && av == 4)   chk("A_lreq_row0", 32'({a_lr, a_lry}), 32'({1'b1, 8'd0}));
        if (ah == 260 && av == 164) chk("A_lreq_none_hold", 32'({a_lr, a_lry}), 32'({1'b0, 8'd159}));
        if (ah == 260 && av == 175) chk("A_lreq_frame_wrap", 32'(a_lr), 32'(0));
        if (bh == 5 && bv == 5)     chk("B_win_first", 32'({b_win, b_gx, b_gy}), 32'({1'b1, 8'd0, 8'd0}));
        if (bh == 8 && bv == 7)     chk("B_gx_step", 32'({b_win, b_gx, b_gy}), 32'({1'b1, 8'd1, 8'd0}));
        if (bh == 11 && bv == 8)    chk("B_gxy_step", 32'({b_win, b_gx, b_gy}), 32'({1'b1, 8'd2, 8'd1}));
        if (bh == 724 && bv == 6)   chk("B_gx_last", 32'({b_win, b_gx}), 32'({1'b1, 8'd239}));
        if (bh == 725 && bv == 6)   chk("B_win_after", 32'(b_win), 32'(0));
        if (bh == 730 && bv == 6)   chk("B_lreq_mid_row", 32'({b_lr, b_lry}), 32'({1'b0, 8'd0}));
        if (bh == 730 && bv == 7)   chk("B_lreq_row1", 32'({b_lr, b_lry}), 32'({1'b1, 8'd1}));

        if (stats_en) begin
            if (a_lr && n_cyc <= A_FRAME) begin
                lr_cnt++;
                if (first_lr_n == 0) begin
                    first_lr_n = n_cyc;
                    first_lr_y = a_lry;
                end
                last_lr_n = n_cyc;
                last_lr_y = a_lry;
            end
            if (a_fs && n_cyc > 1 && fs2_n == 0) fs2_n = n_cyc;
            if (a_hs && n_cyc <= A_HT) begin
                hs_cnt++;
                if (hs_first == 0) hs_first = n_cyc;
            end
        end

        ah++;
        if (ah == A_HT) begin
            ah = 0;
            av = (av == A_VT - 1) ? 0 : av + 1;
        end
        bh++;
        if (bh == B_HT) begin
            bh = 0;
            bv = (bv == B_VT - 1) ? 0 : bv + 1;
        end
    endtask

    initial begin
        stats_en = 1'b0;
        lr_cnt = 0; first_lr_n = 0; last_lr_n = 0; fs2_n = 0; hs_cnt = 0; hs_first = 0;
        first_lr_y = 8'd0; last_lr_y = 8'd0;
        restart_model();
        rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("A_reset_outputs", 32'(a_vec), 32'(0));
        chk("B_reset_outputs", 32'(b_vec), 32'(0));
        rst = 1'b0;

        stats_en = 1'b1;
        // Full frame of A, then into frame 2 up to v=20, h=99.
        for (int i = 0; i < A_FRAME + 20 * A_HT + 100; i++) sample_cycle();
        stats_en = 1'b0;

        chk("A_lreq_count", 32'(lr_cnt), 32'(160));
        chk("A_lreq_first_cyc", 32'(first_lr_n), 32'(1349));
        chk("A_lreq_first_y", 32'(first_lr_y), 32'(0));
        chk("A_lreq_last_cyc", 32'(last_lr_n), 32'(44597));
        chk("A_lreq_last_y", 32'(last_lr_y), 32'(159));
        chk("A_frame_period", 32'(fs2_n - 1), 32'(47872));
        chk("A_hsync_len", 32'(hs_cnt), 32'(6));
        chk("A_hsync_first_cyc", 32'(hs_first), 32'(265));

        rst = 1'b1;
        @(negedge clk);
        chk("A_midframe_reset", 32'(a_vec), 32'(0));
        chk("B_midframe_reset", 32'(b_vec), 32'(0));
        rst = 1'b0;
        restart_model();
        for (int i = 0; i < 2000; i++) sample_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
